pio_bank: RTL
=============

PIO_BANK -- requirements
Module: pio_bank

Interface
REQ-001 SHALL have parameter OUT_W, default 8: width of output (LED) port, 1..32.
REQ-002 SHALL have parameter IN_W, default 10: width of input (switch) port, 1..32.
REQ-003 SHALL have parameter DEB_CYCLES, default 16: cycles an input must hold stable before acceptance, >=2.
REQ-004 SHALL have port clk_clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset_reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port avs_address  in  3  word address of register.
REQ-007 SHALL have ports avs_read / avs_write  in  1  Avalon-MM read/write strobes, single-cycle, never both high.
REQ-008 SHALL have port avs_writedata  in  32  write data.
REQ-009 SHALL have port avs_readdata  out  32  read data.
REQ-010 SHALL have port irq  out  1  level interrupt, active-high.
REQ-011 SHALL have port led_wire_export  out  OUT_W  output register value.
REQ-012 SHALL have port sw_wire_export  in  IN_W  asynchronous external inputs.

Function
REQ-013 SHALL decode: 0 DATA_IN (RO), 1 DATA_OUT (RW), 2 OUT_SET (WO, write-1-set), 3 OUT_CLR (WO, write-1-clear), 4 IRQ_MASK (RW, IN_W bits), 5 EDGE_CAP (read; write-1-clear), 6 EDGE_MODE (RW, 2 bits: 0 rising, 1 falling, 2 both, 3 none), 7 reserved (reads 0, writes ignored).
REQ-014 SHALL return avs_readdata one cycle after avs_read (fixed latency 1), zero-extended; write-only and reserved addresses read 0.
REQ-015 SHALL ignore writedata bits above the register width.
REQ-016 SHALL update led_wire_export the cycle after an accepted write to 1, 2 or 3.
REQ-017 SHALL pass each sw_wire_export bit through a 2-flop synchroniser, then a per-bit debouncer.
REQ-018 Debouncer SHALL increment a counter while synchronised bit differs from debounced bit, clear it when equal, and set debounced bit = synchronised bit and clear counter when counter reaches DEB_CYCLES-1.
REQ-019 Input-to-DATA_IN latency for a clean step SHALL be exactly 2 + DEB_CYCLES cycles; glitches shorter than DEB_CYCLES SHALL never reach DATA_IN.
REQ-020 SHALL set EDGE_CAP[i] the cycle a debounced bit changes in the direction selected by EDGE_MODE.
REQ-021 When an edge and a write-1-clear hit the same EDGE_CAP bit in one cycle, set SHALL win.
REQ-022 irq SHALL be registered: irq = |(EDGE_CAP & IRQ_MASK) one cycle after either operand changes.
REQ-023 Changing EDGE_MODE SHALL not alter existing EDGE_CAP bits.

Reset
REQ-024 On reset_reset_n low, SHALL asynchronously clear DATA_OUT, led_wire_export, IRQ_MASK, EDGE_CAP, EDGE_MODE (rising), irq, avs_readdata, synchronisers, counters and debounced values to 0.
REQ-025 After reset release, SHALL not flag edges for inputs already high until after the debounce latency; the resulting 0->1 debounced change SHALL set EDGE_CAP if rising is selected.
REQ-026 Reset asserted mid-read SHALL abandon the read; avs_readdata SHALL be 0.

Structure
REQ-027 Register address constants and EDGE_MODE encodings SHALL live in shared package pio_bank_pkg.
REQ-028 Per-bit synchroniser plus debouncer SHALL be sub-module pio_debounce, instantiated IN_W times via generate.
REQ-029 Counter width SHALL be $clog2(DEB_CYCLES).

Verification
REQ-030 Write 0xA5 to addr 1, read addr 1 -> led_wire_export=0xA5 next cycle, readdata 0xA5 one cycle after read.
REQ-031 DATA_OUT=0x0F, write 0xF0 to addr 2 then 0x03 to addr 3 -> led_wire_export 0xFF then 0xFC.
REQ-032 sw bit 0 pulses high 10 cycles (DEB_CYCLES=16) -> DATA_IN stays 0, EDGE_CAP 0, irq 0.
REQ-033 sw bit 3 steps high, IRQ_MASK=0x008, mode rising -> DATA_IN[3]=1 after 18 cycles, EDGE_CAP=0x008, irq high next cycle; write 0x008 to addr 5 -> irq low.
REQ-034 Mode falling, bit 3 edge coincides with write-1-clear of bit 3 -> EDGE_CAP[3] remains 1.
REQ-035 Assert reset while DATA_OUT=0xFF and EDGE_CAP nonzero -> all outputs 0 immediately, without clock edge.

Source files
------------

// File: rtl/pio_bank_pkg.sv
// rtl/pio_bank_pkg.sv - shared register map and edge-mode encodings for pio_bank
//
// Purpose : register word addresses, EDGE_MODE encodings and the edge
//           qualification helper used by the PIO bank register block.
// Ports   : none (package).

package pio_bank_pkg;

  // Register word addresses (avs_address)
  localparam logic [2:0] ADDR_DATA_IN   = 3'd0;  // RO  debounced inputs
  localparam logic [2:0] ADDR_DATA_OUT  = 3'd1;  // RW  output register
  localparam logic [2:0] ADDR_OUT_SET   = 3'd2;  // WO  write-1-set of DATA_OUT
  localparam logic [2:0] ADDR_OUT_CLR   = 3'd3;  // WO  write-1-clear of DATA_OUT
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd4;  // RW  per-input interrupt enable
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd5;  // R / write-1-clear edge capture
  localparam logic [2:0] ADDR_EDGE_MODE = 3'd6;  // RW  edge selection
  localparam logic [2:0] ADDR_RESERVED  = 3'd7;  // reads 0, writes ignored

  localparam int unsigned BUS_W = 32;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_BOTH    = 2'd2,
    EDGE_NONE    = 2'd3
  } edge_mode_e;

  // Does a debounced transition count as a captured edge under this mode?
  function automatic logic edge_hit(input edge_mode_e mode,
                                    input logic       rise,
                                    input logic       fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISING:  hit = rise;
      EDGE_FALLING: hit = fall;
      EDGE_BOTH:    hit = rise | fall;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// rtl/pio_debounce.sv - per-bit 2-flop synchroniser plus counting debouncer
//
// Purpose : brings one asynchronous input into the clk_i domain and only
//           accepts a new level once it has differed from the accepted
//           level for DEB_CYCLES consecutive cycles.
// Ports   : clk_i    - rising-edge clock
//           rst_ni   - asynchronous active-low reset
//           async_i  - raw external input
//           deb_o    - debounced level
//           rise_o   - high in the cycle before deb_o goes 0->1
//           fall_o   - high in the cycle before deb_o goes 1->0

module pio_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter measures how long the synchronised level has disagreed with
  // the accepted level; any agreement restarts the measurement, so short
  // glitches never accumulate across separate pulses.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  // Transition flags lead deb_o by one cycle so the capture register can
  // be set on the same edge that the debounced level changes.
  assign deb_o  = deb_q;
  assign rise_o = ~deb_q & deb_d;
  assign fall_o = deb_q & ~deb_d;

endmodule

// File: rtl/pio_bank.sv
// rtl/pio_bank.sv - Avalon-MM parallel I/O bank with debounced inputs and edge IRQ
//
// Purpose : LED output register with set/clear aliases, debounced switch
//           inputs, per-input edge capture and a masked level interrupt.
// Ports   : clk_clk          - rising-edge clock
//           reset_reset_n    - asynchronous active-low reset
//           avs_address      - register word address
//           avs_read         - read strobe, data returned one cycle later
//           avs_write        - write strobe
//           avs_writedata    - write data
//           avs_readdata     - registered, zero-extended read data
//           irq              - registered level interrupt
//           led_wire_export  - DATA_OUT register
//           sw_wire_export   - asynchronous switch inputs

module pio_bank
  import pio_bank_pkg::*;
#(
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned IN_W       = 10,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  output logic [OUT_W-1:0] led_wire_export,
  input  logic [IN_W-1:0]  sw_wire_export
);

  logic [IN_W-1:0]  deb;
  logic [IN_W-1:0]  deb_rise;
  logic [IN_W-1:0]  deb_fall;

  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic [IN_W-1:0]  irq_mask_q, irq_mask_d;
  logic [IN_W-1:0]  edge_cap_q, edge_cap_d;
  edge_mode_e       edge_mode_q, edge_mode_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [IN_W-1:0]  edge_set;
  logic [IN_W-1:0]  edge_clr;
  logic [31:0]      rd_mux;

  // Write data above each register's width is intentionally discarded.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  genvar g;
  generate
    for (g = 0; g < IN_W; g++) begin : g_in
      pio_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_debounce (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .async_i (sw_wire_export[g]),
        .deb_o   (deb[g]),
        .rise_o  (deb_rise[g]),
        .fall_o  (deb_fall[g])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read mux (zero-extended, sampled from current register state)
  // ---------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA_IN:   rd_mux[IN_W-1:0]  = deb;
      ADDR_DATA_OUT:  rd_mux[OUT_W-1:0] = data_out_q;
      ADDR_IRQ_MASK:  rd_mux[IN_W-1:0]  = irq_mask_q;
      ADDR_EDGE_CAP:  rd_mux[IN_W-1:0]  = edge_cap_q;
      ADDR_EDGE_MODE: rd_mux[1:0]       = edge_mode_q;
      default:        rd_mux            = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------
  always_comb begin
    data_out_d  = data_out_q;
    irq_mask_d  = irq_mask_q;
    edge_mode_d = edge_mode_q;
    edge_clr    = '0;
    readdata_d  = readdata_q;

    if (avs_write) begin
      case (avs_address)
        ADDR_DATA_OUT:  data_out_d  = avs_writedata[OUT_W-1:0];
        ADDR_OUT_SET:   data_out_d  = data_out_q | avs_writedata[OUT_W-1:0];
        ADDR_OUT_CLR:   data_out_d  = data_out_q & ~avs_writedata[OUT_W-1:0];
        ADDR_IRQ_MASK:  irq_mask_d  = avs_writedata[IN_W-1:0];
        ADDR_EDGE_CAP:  edge_clr    = avs_writedata[IN_W-1:0];
        ADDR_EDGE_MODE: edge_mode_d = edge_mode_e'(avs_writedata[1:0]);
        default:        ;
      endcase
    end

    if (avs_read) begin
      readdata_d = rd_mux;
    end

    // Edges are qualified with the mode in force now; a mode change only
    // affects future transitions, never bits already captured.
    for (int i = 0; i < IN_W; i++) begin
      edge_set[i] = edge_hit(edge_mode_q, deb_rise[i], deb_fall[i]);
    end

    // Clear first, then set, so a coincident edge is never lost.
    edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;

    irq_d = |(edge_cap_q & irq_mask_q);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_out_q  <= '0;
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
      edge_mode_q <= EDGE_RISING;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      data_out_q  <= data_out_d;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      edge_mode_q <= edge_mode_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

  assign led_wire_export = data_out_q;
  assign irq             = irq_q;
  assign avs_readdata    = readdata_q;

endmodule
